// File: rtl/if_fetch_pkg.sv
// Shared constants and state codes for the instruction-fetch stage.
// Imported by the fetch FSM and its buffer.
package if_fetch_pkg;

    localparam logic        RstEnable    = 1'b0;
    localparam logic        StallNo      = 1'b0;
    localparam logic [31:0] ZeroInst     = 32'h0000_0000;
    localparam logic [31:0] ZeroInstAddr = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_buf.sv
// Small synchronous FIFO holding {pc, inst} pairs between imem and if_id.
// Flush wins over push and pop; storage is not reset, only the pointers.
module if_fetch_buf
    import if_fetch_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single-outstanding imem requests,
// redirect handling and a small buffer feeding the if_id register.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_valid,
    output logic              stallreq_if
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int W  = ADDR_W + DATA_W;

    fetch_state_e      state;
    fetch_state_e      state_n;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_n;

    logic              push;
    logic              pop;
    logic              room;
    logic [W-1:0]      head;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_inst;

    if_fetch_buf #(
        .W     (W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (branch_flag),
        .din   ({fetch_pc, imem_rdata}),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign pop  = (stall == StallNo) & ~empty;
    // Space left once this cycle's pop and push have both landed.
    assign room = (count - CW'(pop)) < CW'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        push       = 1'b0;
        imem_req   = (state == REQ);
        imem_addr  = fetch_pc;
        unique case (state)
            IDLE: begin
                if (branch_flag) begin
                    fetch_pc_n = branch_target;
                end else if (!full) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (branch_flag) begin
                    fetch_pc_n = branch_target;
                    state_n    = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_n = fetch_pc + ADDR_W'(4);
                    state_n    = room ? REQ : IDLE;
                end
            end
            DROP: begin
                if (branch_flag) fetch_pc_n = branch_target;
                if (imem_ack)    state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign {head_pc, head_inst} = head;

    assign if_valid    = ~empty;
    assign stallreq_if = empty;
    assign if_pc       = empty ? ADDR_W'(ZeroInstAddr) : head_pc;
    assign if_inst     = empty ? DATA_W'(ZeroInst) : head_inst;

endmodule
